// File: rtl/nano_lockstep_checker.sv
// nano_lockstep_checker
// Lockstep checker: one golden NanoController against NUM_DUT_G ISA variants.
// Golden output-change events ({sleep, func}) go into a shared event FIFO with one
// read pointer per DUT channel. Each DUT output change is compared in order against
// that channel's oldest pending golden event, so channels may run ahead or behind.
// Build option: define NANO_LSCHK_TIMEOUT_EN to add per-channel head-age timeouts
// (o_tmo); without it o_tmo is tied low and pending events wait indefinitely.
module nano_lockstep_checker #(
  parameter int NUM_DUT_G  = 2,
  parameter int FUNC_W_G   = 72,
  parameter int DEPTH_G    = 8,
  parameter int SKEW_WIN_G = 16,
  parameter int CNT_W_G    = 8
) (
  input  logic                          i_nano_clk,
  input  logic                          i_nano_rst,
  input  logic                          i_en,
  input  logic                          i_clr,
  input  logic                          i_nano_sleep_golden,
  input  logic [FUNC_W_G-1:0]           i_nano_func_golden,
  input  logic [NUM_DUT_G-1:0]          i_nano_sleep_dut,
  input  logic [NUM_DUT_G*FUNC_W_G-1:0] i_nano_func_dut,
  output logic [NUM_DUT_G-1:0]          o_err,
  output logic [NUM_DUT_G-1:0]          o_ovf,
  output logic [NUM_DUT_G-1:0]          o_tmo,
  output logic [NUM_DUT_G*CNT_W_G-1:0]  o_err_cnt,
  output logic                          o_armed
);

  localparam int WORD_W = FUNC_W_G + 1;
  localparam int IDX_W  = $clog2(DEPTH_G);
  localparam int PTR_W  = IDX_W + 1;  // extra wrap bit separates full from empty

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef enum logic {ST_DISARMED, ST_ARMED} state_t;

  if (DEPTH_G < 2 || (DEPTH_G & (DEPTH_G - 1)) != 0 || SKEW_WIN_G < 1 ||
      NUM_DUT_G < 1 || NUM_DUT_G > 8) begin : g_cfg_check
    $error("nano_lockstep_checker: illegal parameter set");
  end

  state_t               state_q, state_d;
  logic                 arm, disarm, active;
  word_t                w_g;
  word_t                w_d      [NUM_DUT_G];
  word_t                prev_g_q;
  word_t                prev_d_q [NUM_DUT_G];
  word_t                mem      [DEPTH_G];
  ptr_t                 wp_q, wp_d;
  ptr_t                 rp_q     [NUM_DUT_G];
  ptr_t                 rp_d     [NUM_DUT_G];
  logic                 g_evt, g_acc;
  logic [NUM_DUT_G-1:0] d_evt, full, empty, adv, mism, ovf_set;
  logic [NUM_DUT_G-1:0] err_q, ovf_q;
  logic [CNT_W_G-1:0]   cnt_q    [NUM_DUT_G];

`ifdef NANO_LSCHK_TIMEOUT_EN
  localparam int AGE_W = $clog2(SKEW_WIN_G + 1);
  logic [AGE_W-1:0]     age_q    [NUM_DUT_G];
  logic [AGE_W-1:0]     age_d    [NUM_DUT_G];
  logic [NUM_DUT_G-1:0] tmo_set, tmo_q;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge i_nano_clk or posedge i_nano_rst) begin
    if (i_nano_rst) state_q <= ST_DISARMED;
    else            state_q <= state_d;
  end

  // Arm on enable, fall back to disarmed whenever enable is released.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    arm     = 1'b0;
    disarm  = 1'b0;
    active  = 1'b0;
    case (state_q)
      ST_DISARMED: if (i_en) begin
        state_d = ST_ARMED;
        arm     = 1'b1;
      end
      ST_ARMED: if (i_en) begin
        active  = 1'b1;
      end else begin
        state_d = ST_DISARMED;
        disarm  = 1'b1;
      end
      default: state_d = ST_DISARMED;
    endcase
  end

  // Build sample words and detect per-source output changes.
  always_comb begin
    w_g   = {i_nano_sleep_golden, i_nano_func_golden};
    d_evt = '0;
    for (int c = 0; c < NUM_DUT_G; c++) begin
      w_d[c]   = {i_nano_sleep_dut[c], i_nano_func_dut[c*FUNC_W_G +: FUNC_W_G]};
      d_evt[c] = (w_d[c] != prev_d_q[c]);
    end
  end

  // Event routing: golden push/drop, per-channel compare against head or bypass, timeout pops.
  always_comb begin
    g_evt   = (w_g != prev_g_q);
    full    = '0;
    empty   = '0;
    adv     = '0;
    mism    = '0;
    ovf_set = '0;
`ifdef NANO_LSCHK_TIMEOUT_EN
    tmo_set = '0;
`endif
    for (int c = 0; c < NUM_DUT_G; c++) begin
      full[c]  = (ptr_t'(wp_q - rp_q[c]) == ptr_t'(DEPTH_G));
      empty[c] = (rp_q[c] == wp_q);
    end
    // A single full channel blocks the write for everyone so all channels see one history.
    g_acc   = g_evt && (full == '0);
    wp_d    = g_acc ? ptr_t'(wp_q + 1'b1) : wp_q;
    ovf_set = g_evt ? full : '0;
    for (int c = 0; c < NUM_DUT_G; c++) begin
      if (d_evt[c]) begin
        if (!empty[c]) begin
          mism[c] = (w_d[c] != mem[rp_q[c][IDX_W-1:0]]);
          adv[c]  = 1'b1;
        end else if (g_acc) begin
          mism[c] = (w_d[c] != w_g);
          adv[c]  = 1'b1;
        end else begin
          mism[c] = 1'b1;  // DUT changed with nothing to match
        end
      end
`ifdef NANO_LSCHK_TIMEOUT_EN
      age_d[c] = age_q[c];
      if (adv[c]) begin
        age_d[c] = '0;
      end else if (!empty[c]) begin
        if (age_q[c] == AGE_W'(SKEW_WIN_G - 1)) begin
          adv[c]     = 1'b1;
          tmo_set[c] = 1'b1;
          mism[c]    = 1'b1;
          age_d[c]   = '0;
        end else begin
          age_d[c] = age_q[c] + 1'b1;
        end
      end
`endif
      rp_d[c] = rp_q[c] + ptr_t'(adv[c]);
    end
  end

  // Pointers and previous-word registers.
  always_ff @(posedge i_nano_clk or posedge i_nano_rst) begin
    if (i_nano_rst) begin
      wp_q     <= '0;
      prev_g_q <= '0;
      for (int c = 0; c < NUM_DUT_G; c++) begin
        rp_q[c]     <= '0;
        prev_d_q[c] <= '0;
      end
    end else if (arm) begin
      prev_g_q <= w_g;
      for (int c = 0; c < NUM_DUT_G; c++) prev_d_q[c] <= w_d[c];
    end else if (disarm) begin
      wp_q <= '0;
      for (int c = 0; c < NUM_DUT_G; c++) rp_q[c] <= '0;
    end else if (active) begin
      wp_q     <= wp_d;
      prev_g_q <= w_g;
      for (int c = 0; c < NUM_DUT_G; c++) begin
        rp_q[c]     <= rp_d[c];
        prev_d_q[c] <= w_d[c];
      end
    end
  end

  // Event storage write.
  // NOTE: the event store has no reset; a slot is only read after it has been written.
  always_ff @(posedge i_nano_clk) begin
    if (active && g_acc) mem[wp_q[IDX_W-1:0]] <= w_g;
  end

  // Sticky flags and saturating error counters; clear wins over same-cycle updates.
  always_ff @(posedge i_nano_clk or posedge i_nano_rst) begin
    if (i_nano_rst) begin
      err_q <= '0;
      ovf_q <= '0;
      for (int c = 0; c < NUM_DUT_G; c++) cnt_q[c] <= '0;
    end else if (i_clr) begin
      err_q <= '0;
      ovf_q <= '0;
      for (int c = 0; c < NUM_DUT_G; c++) cnt_q[c] <= '0;
    end else if (active) begin
      err_q <= err_q | mism;
      ovf_q <= ovf_q | ovf_set;
      for (int c = 0; c < NUM_DUT_G; c++) begin
        if (mism[c] && (cnt_q[c] != '1)) cnt_q[c] <= cnt_q[c] + 1'b1;
      end
    end
  end

`ifdef NANO_LSCHK_TIMEOUT_EN
  // Head-age counters and sticky timeout flags.
  always_ff @(posedge i_nano_clk or posedge i_nano_rst) begin
    if (i_nano_rst) begin
      tmo_q <= '0;
      for (int c = 0; c < NUM_DUT_G; c++) age_q[c] <= '0;
    end else begin
      if (i_clr)       tmo_q <= '0;
      else if (active) tmo_q <= tmo_q | tmo_set;
      for (int c = 0; c < NUM_DUT_G; c++) begin
        if (disarm)      age_q[c] <= '0;
        else if (active) age_q[c] <= age_d[c];
      end
    end
  end

  assign o_tmo = tmo_q;
`else
  assign o_tmo = '0;
`endif

  // Flatten per-channel counters onto the output bus.
  always_comb begin
    o_err_cnt = '0;
    for (int c = 0; c < NUM_DUT_G; c++) o_err_cnt[c*CNT_W_G +: CNT_W_G] = cnt_q[c];
  end

  assign o_err   = err_q;
  assign o_ovf   = ovf_q;
  assign o_armed = (state_q == ST_ARMED);

endmodule

// File: tb/tb_nano_lockstep_checker.sv
// tb_nano_lockstep_checker
// Directed scenarios plus randomized traffic, checked every cycle against a
// queue-based reference model (golden history as a queue, per-channel read counts).
// Honours NANO_LSCHK_TIMEOUT_EN the same way the design does.
module tb_nano_lockstep_checker;

  localparam int NUM   = 2;
  localparam int FW    = 72;
  localparam int DEPTH = 8;
  localparam int SKEW  = 16;
  localparam int CW    = 8;
  localparam int WW    = FW + 1;
  localparam int CMAX  = (1 << CW) - 1;

  typedef logic [WW-1:0] word_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              clr;
  logic              sleep_g;
  logic [FW-1:0]     func_g;
  logic [NUM-1:0]    sleep_d;
  logic [NUM*FW-1:0] func_d;
  logic [NUM-1:0]    err, ovf, tmo;
  logic [NUM*CW-1:0] err_cnt;
  logic              armed;

  always #5 clk = ~clk;

  nano_lockstep_checker #(
    .NUM_DUT_G (NUM),
    .FUNC_W_G  (FW),
    .DEPTH_G   (DEPTH),
    .SKEW_WIN_G(SKEW),
    .CNT_W_G   (CW)
  ) dut (
    .i_nano_clk         (clk),
    .i_nano_rst         (rst),
    .i_en               (en),
    .i_clr              (clr),
    .i_nano_sleep_golden(sleep_g),
    .i_nano_func_golden (func_g),
    .i_nano_sleep_dut   (sleep_d),
    .i_nano_func_dut    (func_d),
    .o_err              (err),
    .o_ovf              (ovf),
    .o_tmo              (tmo),
    .o_err_cnt          (err_cnt),
    .o_armed            (armed)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit             m_armed;
  word_t          m_prev_g;
  word_t          m_prev_d [NUM];
  word_t          evq [$];       // every accepted golden event since arming
  int             m_wr;          // events accepted
  int             m_rd [NUM];    // events consumed per channel
  logic [NUM-1:0] m_err, m_ovf, m_tmo;
  int             m_cnt [NUM];
`ifdef NANO_LSCHK_TIMEOUT_EN
  int             m_age [NUM];
`endif

  function automatic word_t get_g();
    return {sleep_g, func_g};
  endfunction

  function automatic word_t get_d(input int c);
    return {sleep_d[c], func_d[c*FW +: FW]};
  endfunction

  task automatic set_g(input word_t w);
    {sleep_g, func_g} = w;
  endtask

  task automatic set_d(input int c, input word_t w);
    sleep_d[c]         = w[FW];
    func_d[c*FW +: FW] = w[FW-1:0];
  endtask

  function automatic word_t rand_word();
    return {1'($urandom_range(0, 1)), 72'($urandom_range(0, 7))};
  endfunction

  task automatic model_reset();
    m_armed  = 1'b0;
    m_prev_g = '0;
    evq.delete();
    m_wr  = 0;
    m_err = '0;
    m_ovf = '0;
    m_tmo = '0;
    for (int c = 0; c < NUM; c++) begin
      m_prev_d[c] = '0;
      m_rd[c]     = 0;
      m_cnt[c]    = 0;
`ifdef NANO_LSCHK_TIMEOUT_EN
      m_age[c]    = 0;
`endif
    end
  endtask

  // One rising edge of the model, using the inputs currently applied.
  task automatic model_step();
    bit    mis [NUM];
    bit    ovs [NUM];
    bit    tms [NUM];
    word_t g;
    word_t d;
    bit    g_evt, g_acc, any_full, did_adv;
    int    pend;
    for (int c = 0; c < NUM; c++) begin
      mis[c] = 0; ovs[c] = 0; tms[c] = 0;
    end
    if (rst) begin
      model_reset();
      return;
    end
    if (!m_armed) begin
      if (en) begin
        m_armed  = 1'b1;
        m_prev_g = get_g();
        for (int c = 0; c < NUM; c++) m_prev_d[c] = get_d(c);
      end
    end else if (!en) begin
      m_armed = 1'b0;
      evq.delete();
      m_wr = 0;
      for (int c = 0; c < NUM; c++) begin
        m_rd[c] = 0;
`ifdef NANO_LSCHK_TIMEOUT_EN
        m_age[c] = 0;
`endif
      end
    end else begin
      g        = get_g();
      g_evt    = (g != m_prev_g);
      any_full = 0;
      for (int c = 0; c < NUM; c++) begin
        if (m_wr - m_rd[c] == DEPTH) begin
          any_full = 1;
          if (g_evt) ovs[c] = 1;
        end
      end
      g_acc = g_evt && !any_full;
      for (int c = 0; c < NUM; c++) begin
        pend    = m_wr - m_rd[c];
        d       = get_d(c);
        did_adv = 0;
        if (d != m_prev_d[c]) begin
          if (pend > 0) begin
            mis[c]  = (d != evq[m_rd[c]]);
            did_adv = 1;
          end else if (g_acc) begin
            mis[c]  = (d != g);
            did_adv = 1;
          end else begin
            mis[c] = 1;
          end
        end
`ifdef NANO_LSCHK_TIMEOUT_EN
        if (did_adv) m_age[c] = 0;
        else if (pend > 0) begin
          m_age[c]++;
          if (m_age[c] == SKEW) begin
            did_adv  = 1;
            tms[c]   = 1;
            mis[c]   = 1;
            m_age[c] = 0;
          end
        end
`endif
        if (did_adv) m_rd[c]++;
        m_prev_d[c] = d;
      end
      if (g_acc) begin
        evq.push_back(g);
        m_wr++;
      end
      m_prev_g = g;
    end
    if (clr) begin
      m_err = '0; m_ovf = '0; m_tmo = '0;
      for (int c = 0; c < NUM; c++) m_cnt[c] = 0;
    end else begin
      for (int c = 0; c < NUM; c++) begin
        if (mis[c]) begin
          m_err[c] = 1'b1;
          if (m_cnt[c] < CMAX) m_cnt[c]++;
        end
        if (ovs[c]) m_ovf[c] = 1'b1;
        if (tms[c]) m_tmo[c] = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    logic [NUM*CW-1:0] exp_cnt;
    exp_cnt = '0;
    for (int c = 0; c < NUM; c++) exp_cnt[c*CW +: CW] = CW'(m_cnt[c]);
    check("armed",   armed,   m_armed);
    check("err",     err,     m_err);
    check("ovf",     ovf,     m_ovf);
    check("tmo",     tmo,     m_tmo);
    check("err_cnt", err_cnt, exp_cnt);
  endtask

  // Advance one clock: model follows the edge, outputs checked 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  word_t seq_g  [5];
  word_t seq_d0 [5];
  word_t w;

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    sleep_g = '0; func_g = '0; sleep_d = '0; func_d = '0;
    model_reset();
    #3;
    compare_all();
    tick();
    rst = 1'b0;
    tick();

    // Arm and run identical sequences on all sources.
    en = 1'b1;
    tick();
    check("armed_rise", armed, 1'b1);
    for (int v = 1; v <= 3; v++) begin
      set_g(word_t'(v)); set_d(0, word_t'(v)); set_d(1, word_t'(v));
      tick();
    end
    check("same_err", err, 2'b00);
    check("same_cnt", err_cnt, 16'h0000);

    // DUT1 lags by 3 cycles; DUT0 returns 0x0FF where golden produced 0x0F0.
    seq_g  = '{word_t'('h10), word_t'('h11), word_t'('h0F0), word_t'('h12), word_t'('h13)};
    seq_d0 = '{word_t'('h10), word_t'('h11), word_t'('h0FF), word_t'('h12), word_t'('h13)};
    for (int i = 0; i < 8; i++) begin
      if (i < 5) begin
        set_g(seq_g[i]);
        set_d(0, seq_d0[i]);
      end
      if (i >= 3) set_d(1, seq_g[i-3]);
      tick();
      if (i == 2) begin
        check("lag_err",  err,          2'b01);
        check("lag_cnt0", err_cnt[7:0], 8'd1);
      end
    end
    check("lag_err_end",  err,           2'b01);
    check("lag_cnt1_end", err_cnt[15:8], 8'd0);
    clr = 1'b1; tick(); clr = 1'b0;

    // DUT1 stalls while golden emits DEPTH+1 events: the last one is dropped.
    for (int i = 0; i < 9; i++) begin
      set_g(word_t'('h20 + i));
      if (i < 8) set_d(0, word_t'('h20 + i));
      tick();
    end
    check("ovf_flag", ovf, 2'b10);
    check("ovf_err",  err, 2'b00);
    for (int i = 0; i < 8; i++) begin
      set_d(1, word_t'('h20 + i));
      tick();
    end
    check("ovf_drain_err", err, 2'b00);
    clr = 1'b1; tick(); clr = 1'b0;

    // Golden event that DUT0 never answers.
    set_g(word_t'('h30)); set_d(1, word_t'('h30));
    tick();
    for (int i = 0; i < SKEW; i++) tick();
`ifdef NANO_LSCHK_TIMEOUT_EN
    check("tmo_flag", tmo,          2'b01);
    check("tmo_cnt0", err_cnt[7:0], 8'd1);
`else
    check("tmo_flag", tmo,          2'b00);
    check("tmo_cnt0", err_cnt[7:0], 8'd0);
    set_d(0, word_t'('h30));
    tick();
    check("late_match_err", err, 2'b00);
`endif
    clr = 1'b1; tick(); clr = 1'b0;

    // 300 unexpected changes on channel 0: counter saturates.
    for (int n = 0; n < 300; n++) begin
      set_d(0, (n % 2) ? word_t'('h41) : word_t'('h40));
      tick();
    end
    check("sat_cnt0", err_cnt[7:0], 8'hFF);
    check("sat_err",  err,          2'b01);
    clr = 1'b1; set_d(0, word_t'('h40));
    tick();
    clr = 1'b0;
    check("clr_err", err,     2'b00);
    check("clr_cnt", err_cnt, 16'h0000);

    // Async reset with pending events, then re-arm without spurious events.
    for (int i = 0; i < 3; i++) begin
      set_g(word_t'('h50 + i));
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("rst_armed", armed, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check("rearm", armed, 1'b1);
    tick();
    check("rearm_no_evt", err_cnt, 16'h0000);

    // Randomized traffic with occasional clears and disarms.
    for (int n = 0; n < 2000; n++) begin
      en  = ($urandom_range(0, 59) != 0);
      clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0) set_g(rand_word());
      for (int c = 0; c < NUM; c++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 4 && (m_wr - m_rd[c]) > 0) begin
          w = evq[m_rd[c]];
          set_d(c, w);
        end else if (r < 6 && (m_wr - m_rd[c]) == 0) begin
          set_d(c, get_g());
        end else if (r == 6) begin
          set_d(c, rand_word());
        end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nano_lockstep_checker.md
# nano_lockstep_checker

Synthesizable lockstep checker comparing one golden NanoController instance against `NUM_DUT_G` ISA variants under test. Captures golden output-change events (`{sleep, func}`) into a shared event FIFO with one read pointer per DUT channel. Each DUT output change is checked in order against its channel's next pending golden event, so variants that take more or fewer cycles per step can still be compared. Mismatches, overflows and stalls are reported per channel with sticky flags and saturating error counters.

## Interface
Parameters:
- `NUM_DUT_G`, 2, number of DUT channels (1..8)
- `FUNC_W_G`, 72, function-output width per instance (8 outputs × 9 bits)
- `DEPTH_G`, 8, event FIFO depth; power of two, ≥2
- `SKEW_WIN_G`, 16, max cycles a head event may wait for its DUT (timeout build only)
- `CNT_W_G`, 8, error counter width per channel

Ports:
- `i_nano_clk` in 1 — single clock, all state on rising edge
- `i_nano_rst` in 1 — reset, asynchronous, active-high
- `i_en` in 1 — checking enable
- `i_clr` in 1 — synchronous clear of flags and counters
- `i_nano_sleep_golden` in 1 — golden sleep
- `i_nano_func_golden` in `FUNC_W_G` — golden function outputs
- `i_nano_sleep_dut` in `NUM_DUT_G` — DUT sleep, bit c = channel c
- `i_nano_func_dut` in `NUM_DUT_G*FUNC_W_G` — DUT outputs, slice c at `[c*FUNC_W_G +: FUNC_W_G]`
- `o_err` out `NUM_DUT_G` — sticky mismatch flag
- `o_ovf` out `NUM_DUT_G` — sticky FIFO overflow flag
- `o_tmo` out `NUM_DUT_G` — sticky timeout flag (always 0 without timeout build)
- `o_err_cnt` out `NUM_DUT_G*CNT_W_G` — saturating error count, slice c at `[c*CNT_W_G +: CNT_W_G]`
- `o_armed` out 1 — checker armed

## Operation
- Sample word W = `{sleep, func}`, `FUNC_W_G+1` bits, per source (golden + each DUT).
- FSM: DISARMED → ARMED when `i_en`=1 (loads all previous-word registers with current inputs, no events that cycle). ARMED → DISARMED when `i_en`=0 (clears wp, all rp, age counters; flags/counters retained).
- Event: in ARMED, source's current W ≠ its registered previous W; previous updated every ARMED cycle.
- Pointers: wp and rp[c] are `log2(DEPTH_G)+1` bits, wrap modulo 2·DEPTH_G; channel c empty when rp[c]=wp, full when wp−rp[c]=DEPTH_G.
- Golden event: if no channel full, mem[wp] ← W_golden, wp+1. If any channel full, event dropped for all channels, wp unchanged, `o_ovf[c]` set for each full channel.
- DUT event on c, channel non-empty: compare W_dut[c] with mem[rp[c]]; rp[c]+1.
- DUT event on c, channel empty, simultaneous accepted golden event: compare against W_golden directly (bypass); rp[c]+1 together with wp+1.
- DUT event on c, channel empty, no golden event: unexpected change → counts as mismatch, rp unchanged.
- Mismatch: `o_err[c]`←1, `o_err_cnt[c]` +1, saturating at all-ones.
- `i_clr`=1: clears `o_err`, `o_ovf`, `o_tmo`, counters; has priority over same-cycle set/increment; FIFO state untouched.

## Timing
- Reset: all outputs 0, FSM DISARMED, wp=rp=0, age=0, previous-word registers 0.
- Event sampled at edge k → flags/counters updated at edge k, visible in cycle after k (1-cycle latency).
- `o_armed` rises on the edge where `i_en` is first sampled high; first possible event at following edge.
- Reset asserted mid-operation: immediate async clear to reset state; pending events lost.
- Golden and DUT events in the same cycle on a non-empty channel: write and read both occur; compare uses mem[rp[c]] (old head).

## Configuration
- `NANO_LSCHK_TIMEOUT_EN` defined: per-channel age counter (`$clog2(SKEW_WIN_G+1)` bits) increments each ARMED cycle while channel non-empty. It is cleared on every rp[c] advance. When age reaches `SKEW_WIN_G`, the head is popped (rp+1), `o_tmo[c]` and `o_err[c]` are set, the counter increments, and age is cleared.
- Not defined: no age counters, `o_tmo` tied 0, pending events wait indefinitely.

## Test plan
- NUM_DUT_G=2, identical sequences 0x001→0x002→0x003 on golden and both DUTs, same cycles → `o_err`=0, counts 0.
- DUT1 lags golden by 3 cycles on 5 events → no errors; DUT0 emits 0x0FF where golden emitted 0x0F0 → `o_err`=2'b01, `o_err_cnt[0]`=1 one cycle after the change.
- DUT1 stalled, golden emits 9 events (DEPTH_G=8) → 9th dropped, `o_ovf`=2'b10, wp−rp[1]=8.
- Timeout build, SKEW_WIN_G=16: golden event, DUT0 silent 16 cycles → `o_tmo[0]`=1 and `o_err_cnt[0]`=1 at cycle 16. Non-timeout build, same stimulus → `o_tmo`=0.
- 300 mismatches on channel 0 with CNT_W_G=8 → count saturates at 255. `i_clr` pulse coincident with a mismatch → all flags/counts 0.
- Assert `i_nano_rst` with 3 pending events → outputs 0 immediately, `o_armed`=0. After release and `i_en`, first input cycle generates no event.
